audio_mixer_nch: RTL



---
 rtl/audio_mixer_nch_if.sv | 31 +++
 rtl/audio_mixer_nch.sv | 127 ++++++++++++
 2 files changed

// File: rtl/audio_mixer_nch_if.sv
// Source-side bundle for audio_mixer_nch: packed samples, channel config port, mute,
// and the mixed PCM / bitstream outputs.
interface audio_mixer_nch_if #(
    parameter int NCH  = 4,
    parameter int W    = 8,
    parameter int VOLW = 4,
    parameter int OUTW = 12
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH*W-1:0] samples;
    logic             cfg_we;
    logic [CHW-1:0]   cfg_addr;
    logic [VOLW+1:0]  cfg_data;
    logic             mute;
    logic [OUTW-1:0]  pcm_left;
    logic [OUTW-1:0]  pcm_right;
    logic             mix_strobe;
    logic             audio_left;
    logic             audio_right;

    modport master (
        output samples, cfg_we, cfg_addr, cfg_data, mute,
        input  pcm_left, pcm_right, mix_strobe, audio_left, audio_right
    );

    modport slave (
        input  samples, cfg_we, cfg_addr, cfg_data, mute,
        output pcm_left, pcm_right, mix_strobe, audio_left, audio_right
    );
endinterface

// File: rtl/audio_mixer_nch.sv
// N-channel stereo mixer: one channel MAC per clock, saturating PCM latch per frame and a
// first-order sigma-delta DAC per side. Define MIXER_DITHER_EN to add LFSR dither to the DACs.
module audio_mixer_nch #(
    parameter int NCH   = 4,
    parameter int W     = 8,
    parameter int VOLW  = 4,
    parameter int OUTW  = 12,
    parameter int SHIFT = 2
) (
    input logic              clk,
    input logic              rst,
    audio_mixer_nch_if.slave bus
);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW   = W + VOLW;
    localparam int ACCW = TW + $clog2(NCH);
    localparam int MW   = (ACCW > OUTW) ? ACCW : OUTW;
    localparam logic [CHW-1:0]  LAST_CH = CHW'(NCH - 1);
    localparam logic [OUTW-1:0] OUT_MAX = '1;

    logic [CHW-1:0]           ch;
    logic [NCH-1:0][VOLW-1:0] vol;
    logic [NCH-1:0]           pan_l;
    logic [NCH-1:0]           pan_r;
    logic [ACCW-1:0]          acc_l;
    logic [ACCW-1:0]          acc_r;
    logic [W-1:0]             cur_sample;
    logic [TW-1:0]            term;
    logic [ACCW-1:0]          sum_l;
    logic [ACCW-1:0]          sum_r;
    logic                     frame_end;
    logic [OUTW-1:0]          pcm_l;
    logic [OUTW-1:0]          pcm_r;
    logic                     strobe_q;
    logic [OUTW:0]            dac_l;
    logic [OUTW:0]            dac_r;
    logic [OUTW-1:0]          dac_in_l;
    logic [OUTW-1:0]          dac_in_r;

    function automatic logic [OUTW-1:0] saturate(input logic [ACCW-1:0] raw);
        logic [MW-1:0] shifted;
        shifted = MW'(raw) >> SHIFT;
        return (shifted > MW'(OUT_MAX)) ? OUT_MAX : shifted[OUTW-1:0];
    endfunction

    // The visited channel's sample is taken live; there is no frame-wide snapshot.
    always_comb begin
        cur_sample = bus.samples[int'(ch) * W +: W];
        term       = TW'(cur_sample) * TW'(vol[ch]);
        sum_l      = acc_l + (pan_l[ch] ? ACCW'(term) : '0);
        sum_r      = acc_r + (pan_r[ch] ? ACCW'(term) : '0);
        frame_end  = (ch == LAST_CH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch       <= '0;
            acc_l    <= '0;
            acc_r    <= '0;
            pcm_l    <= '0;
            pcm_r    <= '0;
            strobe_q <= 1'b0;
        end else begin
            ch       <= frame_end ? '0 : ch + 1'b1;
            strobe_q <= frame_end;
            if (frame_end) begin
                acc_l <= '0;
                acc_r <= '0;
                pcm_l <= bus.mute ? '0 : saturate(sum_l);
                pcm_r <= bus.mute ? '0 : saturate(sum_r);
            end else begin
                acc_l <= sum_l;
                acc_r <= sum_r;
            end
        end
    end

    // Defaults of full volume, both sides, let the block mix sensibly before any writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            vol   <= '1;
            pan_l <= '1;
            pan_r <= '1;
        end else if (bus.cfg_we && (int'(bus.cfg_addr) < NCH)) begin
            vol[bus.cfg_addr]   <= bus.cfg_data[VOLW-1:0];
            pan_l[bus.cfg_addr] <= bus.cfg_data[VOLW+1];
            pan_r[bus.cfg_addr] <= bus.cfg_data[VOLW];
        end
    end

`ifdef MIXER_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_comb begin
        dac_in_l = (pcm_l == OUT_MAX) ? OUT_MAX : pcm_l + OUTW'(lfsr[0]);
        dac_in_r = (pcm_r == OUT_MAX) ? OUT_MAX : pcm_r + OUTW'(lfsr[0]);
    end
`else
    assign dac_in_l = pcm_l;
    assign dac_in_r = pcm_r;
`endif

    // The carry out of an OUTW-bit phase accumulator is the bitstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            dac_l <= '0;
            dac_r <= '0;
        end else begin
            dac_l <= {1'b0, dac_l[OUTW-1:0]} + {1'b0, dac_in_l};
            dac_r <= {1'b0, dac_r[OUTW-1:0]} + {1'b0, dac_in_r};
        end
    end

    assign bus.pcm_left    = pcm_l;
    assign bus.pcm_right   = pcm_r;
    assign bus.mix_strobe  = strobe_q;
    assign bus.audio_left  = dac_l[OUTW];
    assign bus.audio_right = dac_r[OUTW];
endmodule
